// File: rtl/wbu_writeback_stage_pkg.sv
// Shared types for the writeback stage: source select, load funct3 codes, state and payload.
// No logic; imported by wbu_writeback_stage and wbu_load_align.
package wbu_writeback_stage_pkg;

   localparam int BITS_W_DEF = 64;
   localparam int GPR_W_DEF  = 5;

   typedef enum logic [1:0] {
      WB_ALU  = 2'd0,
      WB_LOAD = 2'd1,
      WB_PC4  = 2'd2,
      WB_CSR  = 2'd3
   } wb_sel_e;

   localparam logic [2:0] LB  = 3'b000;
   localparam logic [2:0] LH  = 3'b001;
   localparam logic [2:0] LW  = 3'b010;
   localparam logic [2:0] LD  = 3'b011;
   localparam logic [2:0] LBU = 3'b100;
   localparam logic [2:0] LHU = 3'b101;
   localparam logic [2:0] LWU = 3'b110;

   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } wbu_state_e;

   typedef struct packed {
      logic [63:0] pc;
      logic [4:0]  rd;
      logic        reg_wen;
      wb_sel_e     wb_sel;
      logic [63:0] alu;
      logic [63:0] raw;
      logic [2:0]  funct3;
      logic [63:0] csr;
   } wb_payload_t;

endpackage

// File: rtl/wbu_load_align.sv
// Load extraction from an aligned doubleword; purely combinational (0 cycles), no flow control.
// Address bits below the access size are ignored; unknown funct3 yields 0.
module wbu_load_align
   import wbu_writeback_stage_pkg::*;
(
   input  logic [63:0] i_raw,
   input  logic [2:0]  i_off,
   input  logic [2:0]  i_funct3,
   output logic [63:0] o_data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_word;

   assign w_byte = i_raw[{i_off, 3'b000} +: 8];
   assign w_half = i_raw[{i_off[2:1], 4'b0000} +: 16];
   assign w_word = i_raw[{i_off[2], 5'b00000} +: 32];

   always_comb begin
      o_data = '0;
      case (i_funct3)
         LB:      o_data = {{56{w_byte[7]}}, w_byte};
         LH:      o_data = {{48{w_half[15]}}, w_half};
         LW:      o_data = {{32{w_word[31]}}, w_word};
         LD:      o_data = i_raw;
         LBU:     o_data = {56'd0, w_byte};
         LHU:     o_data = {48'd0, w_half};
         LWU:     o_data = {32'd0, w_word};
         default: o_data = '0;
      endcase
   end

endmodule

// File: rtl/wbu_writeback_stage.sv
// Writeback stage: registers the MEM result, drives the GPR write port for one cycle, counts retires.
// Latency 1 cycle, full throughput; WBU_ready drops permanently (until reset) after an ebreak transfer.
module wbu_writeback_stage
   import wbu_writeback_stage_pkg::*;
#(
   parameter int BITS_W = BITS_W_DEF,
   parameter int GPR_W  = GPR_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              MEM_valid,
   output logic              WBU_ready,
   input  logic [BITS_W-1:0] MEM_pc,
   input  logic [GPR_W-1:0]  MEM_rd,
   input  logic              MEM_reg_wen,
   input  logic [1:0]        MEM_wb_sel,
   input  logic [BITS_W-1:0] MEM_alu_res,
   input  logic [BITS_W-1:0] MEM_load_raw,
   input  logic [2:0]        MEM_funct3,
   input  logic [BITS_W-1:0] MEM_csr_rdata,
   input  logic              MEM_ebreak,
   output logic              RegWr,
   output logic [GPR_W-1:0]  WBU_rd,
   output logic [BITS_W-1:0] rf_busW,
   output logic              WBU_commit,
   output logic [BITS_W-1:0] WBU_pc,
   output logic [63:0]       retire_cnt,
   output logic              halted
);

   logic        r_valid;
   wbu_state_e  r_state;
   wb_payload_t r_pl;
   logic [63:0] r_retire_cnt;

   logic        w_xfer;
   logic [63:0] w_load_data;

   assign WBU_ready = (r_state == RUN);
   assign w_xfer    = MEM_valid & WBU_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_valid      <= 1'b0;
         r_state      <= RUN;
         r_pl         <= '0;
         r_retire_cnt <= '0;
      end else begin
         r_valid <= w_xfer;
         if (w_xfer) begin
            r_pl.pc      <= MEM_pc;
            r_pl.rd      <= MEM_rd;
            r_pl.reg_wen <= MEM_reg_wen;
            r_pl.wb_sel  <= wb_sel_e'(MEM_wb_sel);
            r_pl.alu     <= MEM_alu_res;
            r_pl.raw     <= MEM_load_raw;
            r_pl.funct3  <= MEM_funct3;
            r_pl.csr     <= MEM_csr_rdata;
            // The ebreak itself still commits next cycle; only later instructions are refused.
            if (MEM_ebreak) begin
               r_state <= HALT;
            end
         end
         if (r_valid) begin
            r_retire_cnt <= r_retire_cnt + 64'd1;
         end
      end
   end

   wbu_load_align u_load_align (
      .i_raw    (r_pl.raw),
      .i_off    (r_pl.alu[2:0]),
      .i_funct3 (r_pl.funct3),
      .o_data   (w_load_data)
   );

   always_comb begin
      rf_busW = r_pl.alu;
      case (r_pl.wb_sel)
         WB_ALU:  rf_busW = r_pl.alu;
         WB_LOAD: rf_busW = w_load_data;
         WB_PC4:  rf_busW = r_pl.pc + 64'd4;
         WB_CSR:  rf_busW = r_pl.csr;
         default: rf_busW = r_pl.alu;
      endcase
   end

   // x0 writes are dropped here so the register file never needs to special-case them.
   assign RegWr      = r_valid & r_pl.reg_wen & (r_pl.rd != '0);
   assign WBU_rd     = r_pl.rd;
   assign WBU_commit = r_valid;
   assign WBU_pc     = r_pl.pc;
   assign retire_cnt = r_retire_cnt;
   assign halted     = (r_state == HALT);

endmodule

// File: tb/tb_wbu_writeback_stage.sv
// Bench for wbu_writeback_stage: directed plan items plus randomized traffic against a transaction-level model.
module tb_wbu_writeback_stage;

   typedef struct packed {
      logic [63:0] pc;
      logic [4:0]  rd;
      logic        wen;
      logic [1:0]  sel;
      logic [63:0] alu;
      logic [63:0] raw;
      logic [2:0]  f3;
      logic [63:0] csr;
   } ent_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ebreak = 1'b0;
   ent_t        in_e = '0;

   logic        WBU_ready, RegWr, WBU_commit, halted;
   logic [4:0]  WBU_rd;
   logic [63:0] rf_busW, WBU_pc, retire_cnt;

   int n_checks = 0;
   int n_pass   = 0;

   // transaction-level model state
   logic        m_valid;
   logic        m_halt;
   logic [63:0] m_cnt;
   ent_t        m_ent;

   always #5 clk = ~clk;

   wbu_writeback_stage dut (
      .clk           (clk),
      .rst           (rst),
      .MEM_valid     (in_valid),
      .WBU_ready     (WBU_ready),
      .MEM_pc        (in_e.pc),
      .MEM_rd        (in_e.rd),
      .MEM_reg_wen   (in_e.wen),
      .MEM_wb_sel    (in_e.sel),
      .MEM_alu_res   (in_e.alu),
      .MEM_load_raw  (in_e.raw),
      .MEM_funct3    (in_e.f3),
      .MEM_csr_rdata (in_e.csr),
      .MEM_ebreak    (in_ebreak),
      .RegWr         (RegWr),
      .WBU_rd        (WBU_rd),
      .rf_busW       (rf_busW),
      .WBU_commit    (WBU_commit),
      .WBU_pc        (WBU_pc),
      .retire_cnt    (retire_cnt),
      .halted        (halted)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   // Load result by shifting the doubleword down to the naturally aligned slot.
   function automatic logic [63:0] load_ref(input logic [63:0] raw, input logic [63:0] addr,
                                            input logic [2:0] f3);
      int unsigned off;
      logic [63:0] v;
      off = int'(addr % 8);
      case (f3)
         3'd0, 3'd4: begin
            v = (raw >> (8 * off)) & 64'hFF;
            if (f3 == 3'd0 && v >= 64'h80) v = v - 64'h100;
         end
         3'd1, 3'd5: begin
            v = (raw >> (8 * (off / 2 * 2))) & 64'hFFFF;
            if (f3 == 3'd1 && v >= 64'h8000) v = v - 64'h10000;
         end
         3'd2, 3'd6: begin
            v = (raw >> (8 * (off / 4 * 4))) & 64'hFFFF_FFFF;
            if (f3 == 3'd2 && v >= 64'h8000_0000) v = v - 64'h1_0000_0000;
         end
         3'd3:    v = raw;
         default: v = 64'd0;
      endcase
      return v;
   endfunction

   function automatic logic [63:0] wb_ref(input ent_t e);
      case (e.sel)
         2'd0:    return e.alu;
         2'd1:    return load_ref(e.raw, e.alu, e.f3);
         2'd2:    return e.pc + 64'd4;
         default: return e.csr;
      endcase
   endfunction

   task automatic check_outputs();
      check("commit",  {63'd0, WBU_commit}, {63'd0, m_valid});
      check("regwr",   {63'd0, RegWr}, {63'd0, m_valid && m_ent.wen && m_ent.rd != 5'd0});
      check("rd",      {59'd0, WBU_rd}, {59'd0, m_ent.rd});
      check("pc",      WBU_pc, m_ent.pc);
      check("busw",    rf_busW, wb_ref(m_ent));
      check("retire",  retire_cnt, m_cnt);
      check("ready",   {63'd0, WBU_ready}, {63'd0, !m_halt});
      check("halted",  {63'd0, halted}, {63'd0, m_halt});
   endtask

   task automatic model_reset();
      m_valid = 1'b0;
      m_halt  = 1'b0;
      m_cnt   = 64'd0;
      m_ent   = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      if (m_valid) m_cnt = m_cnt + 64'd1;
      if (in_valid && !m_halt) begin
         m_valid = 1'b1;
         m_ent   = in_e;
         if (in_ebreak) m_halt = 1'b1;
      end else begin
         m_valid = 1'b0;
      end
      #1;
      check_outputs();
   endtask

   task automatic drive(input logic v, input logic [63:0] pc, input logic [4:0] rd, input logic wen,
                        input logic [1:0] sel, input logic [63:0] alu, input logic [63:0] raw,
                        input logic [2:0] f3, input logic [63:0] csr, input logic eb);
      in_valid  = v;
      in_e.pc   = pc;
      in_e.rd   = rd;
      in_e.wen  = wen;
      in_e.sel  = sel;
      in_e.alu  = alu;
      in_e.raw  = raw;
      in_e.f3   = f3;
      in_e.csr  = csr;
      in_ebreak = eb;
   endtask

   task automatic drive_rand();
      drive(1'($urandom_range(0, 3) != 0), {$urandom, $urandom}, 5'($urandom), 1'($urandom),
            2'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, 3'($urandom),
            {$urandom, $urandom}, 1'b0);
   endtask

   localparam logic [63:0] RAW = 64'h8877_6655_4433_22F1;

   initial begin
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("rst_regwr", {63'd0, RegWr}, 64'd0);
      check("rst_cnt", retire_cnt, 64'd0);
      check("rst_ready", {63'd0, WBU_ready}, 64'd1);
      check("rst_halted", {63'd0, halted}, 64'd0);
      @(negedge clk);
      rst = 1'b1;
      #1;

      // ALU writeback
      drive(1, 64'h100, 5'd5, 1, 2'd0, 64'h1234, 64'd0, 3'd0, 64'd0, 0);
      tick();
      check("alu_busw", rf_busW, 64'h1234);
      check("alu_rd", {59'd0, WBU_rd}, 64'd5);
      check("alu_regwr", {63'd0, RegWr}, 64'd1);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      check("alu_cnt", retire_cnt, 64'd1);

      // loads from the plan
      drive(1, 64'h104, 5'd6, 1, 2'd1, 64'h2000, RAW, 3'd0, 0, 0);
      tick(); check("lb", rf_busW, 64'hFFFF_FFFF_FFFF_FFF1);
      drive(1, 64'h108, 5'd6, 1, 2'd1, 64'h2000, RAW, 3'd4, 0, 0);
      tick(); check("lbu", rf_busW, 64'hF1);
      drive(1, 64'h10C, 5'd6, 1, 2'd1, 64'h2006, RAW, 3'd1, 0, 0);
      tick(); check("lh", rf_busW, 64'hFFFF_FFFF_FFFF_8877);
      drive(1, 64'h110, 5'd6, 1, 2'd1, 64'h2004, RAW, 3'd6, 0, 0);
      tick(); check("lwu", rf_busW, 64'h8877_6655);
      drive(1, 64'h114, 5'd6, 1, 2'd1, 64'h2000, RAW, 3'd3, 0, 0);
      tick(); check("ld", rf_busW, RAW);
      drive(1, 64'h118, 5'd6, 1, 2'd1, 64'h2000, RAW, 3'd7, 0, 0);
      tick(); check("f3_111", rf_busW, 64'd0);

      // x0 write suppression and JAL link value
      drive(1, 64'h11C, 5'd0, 1, 2'd0, 64'hDEAD, 0, 0, 0, 0);
      tick();
      check("x0_regwr", {63'd0, RegWr}, 64'd0);
      check("x0_commit", {63'd0, WBU_commit}, 64'd1);
      drive(1, 64'h8000_0000, 5'd1, 1, 2'd2, 0, 0, 0, 0, 0);
      tick(); check("jal_link", rf_busW, 64'h8000_0004);
      drive(1, 64'hFFFF_FFFF_FFFF_FFFC, 5'd1, 1, 2'd2, 0, 0, 0, 0, 0);
      tick(); check("pc4_wrap", rf_busW, 64'd0);

      // back-to-back after a fresh reset, then reset while one is held
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk); rst = 1'b0; model_reset(); #1; @(negedge clk); rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive(1, 64'h200 + 64'(4 * i), 5'(i + 1), 1, 2'd0, 64'(i), 0, 0, 0, 0);
         tick();
         check("b2b_commit", {63'd0, WBU_commit}, 64'd1);
      end
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      check("b2b_cnt", retire_cnt, 64'd4);
      drive(1, 64'h300, 5'd9, 1, 2'd0, 64'h55, 0, 0, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      #2;
      rst = 1'b0;
      model_reset();
      #1;
      check("midrst_regwr", {63'd0, RegWr}, 64'd0);
      check("midrst_cnt", retire_cnt, 64'd0);
      @(negedge clk); rst = 1'b1;
      tick();
      check("midrst_cnt2", retire_cnt, 64'd0);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         drive_rand();
         tick();
      end

      // ebreak followed by a valid instruction
      drive(1, 64'h400, 5'd3, 1, 2'd0, 64'h77, 0, 0, 0, 1);
      tick();
      check("eb_commit", {63'd0, WBU_commit}, 64'd1);
      check("eb_ready", {63'd0, WBU_ready}, 64'd0);
      check("eb_halted", {63'd0, halted}, 64'd1);
      drive(1, 64'h404, 5'd4, 1, 2'd0, 64'h88, 0, 0, 0, 0);
      tick();
      check("eb_next_commit", {63'd0, WBU_commit}, 64'd0);
      for (int i = 0; i < 5; i++) tick();
      check("eb_pc_held", WBU_pc, 64'h400);

      // only reset leaves HALT
      @(negedge clk); rst = 1'b0; model_reset(); #1; @(negedge clk); rst = 1'b1;
      #1;
      check("post_halt_ready", {63'd0, WBU_ready}, 64'd1);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
